uart_tx_arbiter: RTL and testbench

//   Shares the single async_transmitter between NUM_REQ byte producers (e.g. terminal

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART transmitter between
//                NUM_REQ byte producers, with optional packet lock and a
//                start/busy handshake sequencer (busy arrives registered).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ID_WIDTH     = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*8-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    locked
);

    localparam int c_CTR_W = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [c_CTR_W-1:0] c_CTR_LAST = c_CTR_W'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_START     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    // Registered state
    logic [1:0]          r_state_q;
    logic [c_CTR_W-1:0]  r_ctr_q;
    logic [7:0]          r_tx_data_q;
    logic [ID_WIDTH-1:0] r_grant_id_q;
    logic                r_locked_q;
    logic [ID_WIDTH-1:0] r_ptr_q;
    logic                r_tx_start_q;

    // Next-state values
    logic [1:0]          w_state_d;
    logic [c_CTR_W-1:0]  w_ctr_d;
    logic [7:0]          w_tx_data_d;
    logic [ID_WIDTH-1:0] w_grant_id_d;
    logic                w_locked_d;
    logic [ID_WIDTH-1:0] w_ptr_d;
    logic                w_tx_start_d;

    // Arbitration
    logic                w_cand_valid;
    logic [ID_WIDTH-1:0] w_cand_sel;
    logic [ID_WIDTH-1:0] w_scan_sel;
    int                  w_scan_idx;
    logic                w_accept;
    logic [NUM_REQ-1:0]  w_req_ready;

    // Pick the candidate: the lock owner only, or the first valid requester
    // at or after the round-robin pointer (pointer tracks grant_id+1, and is
    // 0 straight out of reset so requester 0 wins first).
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_sel   = '0;
        w_scan_idx   = 0;
        w_scan_sel   = '0;
        if (r_locked_q) begin
            w_cand_sel   = r_grant_id_q;
            w_cand_valid = req_valid[r_grant_id_q];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan_idx = int'(r_ptr_q) + k;
                if (w_scan_idx >= NUM_REQ) begin
                    w_scan_idx = w_scan_idx - NUM_REQ;
                end
                w_scan_sel = ID_WIDTH'(w_scan_idx);
                if (!w_cand_valid && req_valid[w_scan_sel]) begin
                    w_cand_valid = 1'b1;
                    w_cand_sel   = w_scan_sel;
                end
            end
        end
    end

    // A byte transfers only from IDLE while the transmitter reports idle
    assign w_accept = (r_state_q == c_ST_IDLE) && !tx_busy && w_cand_valid;

    // One-hot ready toward the selected requester on the transfer cycle
    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_cand_sel] = 1'b1;
        end
    end

    // Handshake sequencer and accept-side bookkeeping
    always_comb begin
        w_state_d    = r_state_q;
        w_ctr_d      = r_ctr_q;
        w_tx_data_d  = r_tx_data_q;
        w_grant_id_d = r_grant_id_q;
        w_locked_d   = r_locked_q;
        w_ptr_d      = r_ptr_q;
        w_tx_start_d = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_tx_data_d  = req_data[8*int'(w_cand_sel) +: 8];
                    w_grant_id_d = w_cand_sel;
                    w_locked_d   = ~req_last[w_cand_sel];
                    w_ptr_d      = (int'(w_cand_sel) == NUM_REQ - 1) ? '0
                                                                     : w_cand_sel + 1'b1;
                    w_tx_start_d = 1'b1;
                    w_state_d    = c_ST_START;
                end
            end
            c_ST_START: begin
                w_ctr_d   = '0;
                w_state_d = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_d = c_ST_WAIT_DONE;
                end else begin
                    // Busy never showed up: give the byte up as sent
                    w_ctr_d = r_ctr_q + 1'b1;
                    if (r_ctr_q == c_CTR_LAST) begin
                        w_state_d = c_ST_IDLE;
                    end
                end
            end
            c_ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_ctr_q      <= '0;
            r_tx_data_q  <= 8'h00;
            r_grant_id_q <= '0;
            r_locked_q   <= 1'b0;
            r_ptr_q      <= '0;
            r_tx_start_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_ctr_q      <= w_ctr_d;
            r_tx_data_q  <= w_tx_data_d;
            r_grant_id_q <= w_grant_id_d;
            r_locked_q   <= w_locked_d;
            r_ptr_q      <= w_ptr_d;
            r_tx_start_q <= w_tx_start_d;
        end
    end

    assign req_ready = w_req_ready;
    assign tx_start  = r_tx_start_q;
    assign tx_data   = r_tx_data_q;
    assign grant_id  = r_grant_id_q;
    assign locked    = r_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed scoreboard bench for uart_tx_arbiter with a
//                transmitter busy model (2-cycle rise, fixed hold).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int ID_WIDTH     = 1;
    localparam int BUSY_TIMEOUT = 4;
    localparam int HOLD         = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 locked;

    // Source queues {last, data}, per-requester enables and accept counters
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic       en0 = 1'b1;
    logic       en1 = 1'b1;
    logic       acc0, acc1;
    int         acc_cnt0 = 0;
    int         acc_cnt1 = 0;

    // Busy model
    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic stuck_low  = 1'b0;
    int   delay_cnt  = 0;
    int   hold_cnt   = 0;
    assign tx_busy = force_busy | model_busy;

    // Scoreboard entries {locked, grant_id, data}
    logic [9:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ID_WIDTH     (ID_WIDTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .locked    (locked)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Requester driver: detect transfers before the edge, advance after it
    initial forever begin
        @(negedge clk);
        acc0 = !rst && req_valid[0] && req_ready[0];
        acc1 = !rst && req_valid[1] && req_ready[1];
        @(posedge clk);
        #1;
        if (acc0) begin
            void'(src0.pop_front());
            acc_cnt0++;
        end
        if (acc1) begin
            void'(src1.pop_front());
            acc_cnt1++;
        end
        req_valid[0] = en0 && (src0.size() > 0);
        req_valid[1] = en1 && (src1.size() > 0);
        if (src0.size() > 0) {req_last[0], req_data[7:0]}  = src0[0];
        if (src1.size() > 0) {req_last[1], req_data[15:8]} = src1[0];
    end

    // Transmitter busy model: busy rises 2 cycles after start, holds HOLD cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (delay_cnt > 0) begin
            delay_cnt--;
            if (delay_cnt == 0) begin
                model_busy = 1'b1;
                hold_cnt   = HOLD;
            end
        end else if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) model_busy = 1'b0;
        end
        if (tx_start && !stuck_low) delay_cnt = 2;
    end

    // Output monitor: every start pulse consumes one scoreboard entry
    initial forever begin
        logic [9:0] e;
        @(posedge clk);
        #2;
        if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("start_with_empty_scoreboard", 32'(exp_q.size() != 0), 1);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
                check("grant_id", 32'(grant_id), 32'(e[8]));
                check("locked", 32'(locked), 32'(e[9]));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int max_cycles, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0 &&
                delay_cnt == 0 && hold_cnt == 0 && !tx_busy) done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #3;
        check(tag, 32'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        logic found;
        logic saw;
        int   cnt;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: single byte from requester 0
        @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 8'h41});
        src0.push_back({1'b1, 8'h41});
        wait_drain(200, "t1_drain");
        check("t1_req0_accepts", 32'(acc_cnt0), 1);
        check("t1_tx_data_held", 32'(tx_data), 32'h41);
        check("t1_ready_idle", 32'(req_ready), 0);

        // Reset so requester 0 regains top priority
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // 2: both requesters valid continuously -> strict alternation
        @(negedge clk);
        src0.push_back({1'b1, 8'h30});
        src0.push_back({1'b1, 8'h30});
        src1.push_back({1'b1, 8'h31});
        src1.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b0, 1'b0, 8'h30});
        exp_q.push_back({1'b0, 1'b1, 8'h31});
        exp_q.push_back({1'b0, 1'b0, 8'h30});
        exp_q.push_back({1'b0, 1'b1, 8'h31});
        wait_drain(400, "t2_drain");

        // 3: packet lock held by requester 1 across a valid gap
        @(negedge clk);
        en0 = 1'b0;
        src0.push_back({1'b1, 8'h20});
        src1.push_back({1'b0, 8'h10});
        src1.push_back({1'b1, 8'h11});
        exp_q.push_back({1'b1, 1'b1, 8'h10});
        exp_q.push_back({1'b0, 1'b1, 8'h11});
        exp_q.push_back({1'b0, 1'b0, 8'h20});
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #3;
            if (src1.size() == 1) found = 1'b1;
        end
        check("t3_first_accept", 32'(src1.size()), 1);
        en1 = 1'b0;
        en0 = 1'b1;
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #3;
            if (req_ready != '0) saw = 1'b1;
        end
        check("t3_no_ready_during_lock", 32'(saw), 0);
        check("t3_locked_held", 32'(locked), 1);
        check("t3_req0_waiting", 32'(src0.size()), 1);
        en1 = 1'b1;
        wait_drain(400, "t3_drain");
        check("t3_unlocked", 32'(locked), 0);

        // 4: busy never rises -> timeout back to IDLE, next byte accepted
        @(negedge clk);
        stuck_low = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 8'h66});
        exp_q.push_back({1'b0, 1'b0, 8'h55});
        src0.push_back({1'b1, 8'h55});
        src1.push_back({1'b1, 8'h66});
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #3;
            if (tx_start) found = 1'b1;
        end
        check("t4_start_seen", 32'(found), 1);
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #3;
            cnt++;
            if (req_ready != '0) found = 1'b1;
        end
        n_checks++;
        assert (found && cnt >= BUSY_TIMEOUT && cnt <= BUSY_TIMEOUT + 1) else begin
            n_fail++;
            $error("FAIL t4_timeout_cycles: observed %0d expected %0d..%0d",
                   cnt, BUSY_TIMEOUT, BUSY_TIMEOUT + 1);
        end
        wait_drain(100, "t4_drain");
        repeat (10) @(posedge clk);
        stuck_low = 1'b0;

        // 5: reset during WAIT_DONE while a locked packet is in flight
        @(negedge clk);
        exp_q.push_back({1'b1, 1'b0, 8'h77});
        src0.push_back({1'b0, 8'h77});
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #3;
            if (tx_busy) found = 1'b1;
        end
        check("t5_busy_seen", 32'(found), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #3;
        check_reset_outputs("t5_reset");
        @(negedge clk);
        rst = 1'b0;
        src1.push_back({1'b1, 8'h78});
        exp_q.push_back({1'b0, 1'b1, 8'h78});
        saw = 1'b0;
        for (int i = 0; i < 30 && tx_busy; i++) begin
            @(posedge clk);
            #3;
            if (tx_busy && req_ready != '0) saw = 1'b1;
        end
        check("t5_no_ready_while_busy", 32'(saw), 0);
        wait_drain(200, "t5_drain");

        // 6: busy high in IDLE blocks acceptance
        @(negedge clk);
        force_busy = 1'b1;
        src0.push_back({1'b1, 8'h99});
        exp_q.push_back({1'b0, 1'b0, 8'h99});
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #3;
            if (req_ready != '0) saw = 1'b1;
        end
        check("t6_no_ready_while_busy", 32'(saw), 0);
        check("t6_req0_pending", 32'(src0.size()), 1);
        force_busy = 1'b0;
        wait_drain(200, "t6_drain");

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
